// File: rtl/bitslice_unswap.sv
// Slice-serial to word-serial register-file rebuild: collects WIDTH slices of
// NREG bits each, then replays the NREG reconstructed words in index order.
module bitslice_unswap #(
    parameter int NREG  = 32,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NREG-1:0]  in_slice,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [4:0]       out_idx,
    output logic             out_last
);
    localparam int WCW = $clog2(WIDTH);
    localparam int RCW = $clog2(NREG);

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]     state_reg, state_next;
    logic [WCW-1:0] wcnt_reg, wcnt_next;
    logic [RCW-1:0] rcnt_reg, rcnt_next;

    logic                       wr_en;
    logic [NREG-1:0][WIDTH-1:0] rows;

    assign in_ready  = (state_reg == FILL);
    assign out_valid = (state_reg == DRAIN);
    assign wr_en     = in_ready && in_valid;

    // Each incoming slice lands as one column: bit wcnt of every row at once,
    // so the image lives in per-row registers rather than a RAM.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_row
            logic [WIDTH-1:0] row_reg;
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    row_reg[wcnt_reg] <= in_slice[gi];
                end
            end
            assign rows[gi] = row_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        wcnt_next  = wcnt_reg;
        rcnt_next  = rcnt_reg;
        case (state_reg)
            FILL: begin
                if (in_valid) begin
                    if (wcnt_reg == WCW'(WIDTH - 1)) begin
                        wcnt_next  = '0;
                        rcnt_next  = '0;
                        state_next = DRAIN;
                    end else begin
                        wcnt_next = wcnt_reg + WCW'(1);
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    if (rcnt_reg == RCW'(NREG - 1)) begin
                        rcnt_next  = '0;
                        state_next = FILL;
                    end else begin
                        rcnt_next = rcnt_reg + RCW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= FILL;
            wcnt_reg  <= '0;
            rcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            wcnt_reg  <= wcnt_next;
            rcnt_reg  <= rcnt_next;
        end
    end

    // Read is combinational off the row registers so word 0 already sees the
    // final slice written on the FILL->DRAIN edge.
    assign out_word = out_valid ? rows[rcnt_reg] : '0;
    assign out_idx  = out_valid ? 5'(rcnt_reg) : 5'd0;
    assign out_last = out_valid && (rcnt_reg == RCW'(NREG - 1));
endmodule
